// File: rtl/pipelined_bus_mux_pkg.sv
// Shared definitions for the pipelined bus multiplexer: FSM encoding,
// transfer-counter width and index-width helper.
package pipelined_bus_mux_pkg;

   localparam int XFER_CNT_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_DRIVE = 2'b01,
      ST_FAULT = 2'b10
   } busState_e;

   // Index width for a source count, never below one bit.
   function automatic int idxWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pipelined_bus_mux_if.sv
// Source/bus bundle of the pipelined bus multiplexer; master drives sources,
// slave is the multiplexer.
interface pipelined_bus_mux_if
   import pipelined_bus_mux_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int NUM_SRC = 24
);
   localparam int IDX_W = idxWidth(NUM_SRC);

   logic [NUM_SRC*WIDTH-1:0] src_data;
   logic [NUM_SRC-1:0]       src_en;
   logic                     err_clr;
   logic [WIDTH-1:0]         bus_out;
   logic                     bus_valid;
   logic [IDX_W-1:0]         sel_idx;
   logic                     conflict;
   logic                     fault;
   logic [XFER_CNT_W-1:0]    xfer_count;

   modport master (
      output src_data, src_en, err_clr,
      input  bus_out, bus_valid, sel_idx, conflict, fault, xfer_count
   );

   modport slave (
      input  src_data, src_en, err_clr,
      output bus_out, bus_valid, sel_idx, conflict, fault, xfer_count
   );

endinterface

// File: rtl/pipelined_bus_mux_prio.sv
// Lowest-index priority encoder with any-set and multi-hot detection.
module onehot_prio_encoder
   import pipelined_bus_mux_pkg::*;
#(
   parameter int  NUM_SRC = 24,
   localparam int IDX_W   = idxWidth(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] en,
   output logic [IDX_W-1:0]   idx,
   output logic               any,
   output logic               multi
);

   // Scan from the top so the lowest set bit is the last one written.
   always_comb begin
      idx = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         idx = en[i] ? IDX_W'(i) : idx;
      end
   end

   // Clearing the lowest set bit leaves something only when two or more were set.
   always_comb begin
      any   = |en;
      multi = |(en & (en - NUM_SRC'(1)));
   end

endmodule

// File: rtl/pipelined_bus_mux.sv
// One-cycle-latency bus multiplexer: priority-selects one of NUM_SRC sources,
// tracks enable conflicts in a small FSM and counts completed transfers.
module pipelined_bus_mux
   import pipelined_bus_mux_pkg::*;
#(
   parameter int WIDTH         = 32,
   parameter int NUM_SRC       = 24,
   parameter bit HOLD_ON_IDLE  = 1'b1,
   parameter bit CONFLICT_MODE = 1'b1
) (
   input logic                clock,
   input logic                clear,
   pipelined_bus_mux_if.slave bus
);
   localparam int IDX_W = idxWidth(NUM_SRC);

   busState_e             stateR;
   busState_e             nextStateS;
   logic [WIDTH-1:0]      busOutR;
   logic                  busValidR;
   logic [IDX_W-1:0]      selIdxR;
   logic                  conflictR;
   logic                  faultR;
   logic [XFER_CNT_W-1:0] xferCountR;

   logic [IDX_W-1:0]      prioIdxS;
   logic                  prioAnyS;
   logic                  prioMultiS;
   logic [WIDTH-1:0]      srcWordS;
   logic                  launchS;

   onehot_prio_encoder #(.NUM_SRC(NUM_SRC)) uPrio (
      .en    (bus.src_en),
      .idx   (prioIdxS),
      .any   (prioAnyS),
      .multi (prioMultiS)
   );

   assign srcWordS = bus.src_data[int'(prioIdxS) * WIDTH +: WIDTH];

   // Next-state decode; FAULT ignores enables except that a fresh multi-enable blocks the exit.
   always_comb begin
      nextStateS = stateR;
      case (stateR)
         ST_IDLE, ST_DRIVE: begin
            if (prioMultiS) begin
               nextStateS = CONFLICT_MODE ? ST_FAULT : ST_DRIVE;
            end else if (prioAnyS) begin
               nextStateS = ST_DRIVE;
            end else begin
               nextStateS = ST_IDLE;
            end
         end
         ST_FAULT: begin
            if (bus.err_clr && !prioMultiS) begin
               nextStateS = ST_IDLE;
            end else begin
               nextStateS = ST_FAULT;
            end
         end
         default: nextStateS = ST_IDLE;
      endcase
   end

   assign launchS = (nextStateS == ST_DRIVE);

   // FSM state, registered bus outputs and saturating transfer counter.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         stateR     <= ST_IDLE;
         busOutR    <= '0;
         busValidR  <= 1'b0;
         selIdxR    <= '0;
         conflictR  <= 1'b0;
         faultR     <= 1'b0;
         xferCountR <= '0;
      end else begin
         stateR    <= nextStateS;
         faultR    <= (nextStateS == ST_FAULT);
         conflictR <= prioMultiS;
         busValidR <= launchS;
         if (launchS) begin
            busOutR <= srcWordS;
            selIdxR <= prioIdxS;
         end else if ((nextStateS == ST_IDLE) && (HOLD_ON_IDLE == 1'b0)) begin
            busOutR <= '0;
         end
         if (launchS && (xferCountR != {XFER_CNT_W{1'b1}})) begin
            xferCountR <= xferCountR + XFER_CNT_W'(1);
         end
      end
   end

   assign bus.bus_out    = busOutR;
   assign bus.bus_valid  = busValidR;
   assign bus.sel_idx    = selIdxR;
   assign bus.conflict   = conflictR;
   assign bus.fault      = faultR;
   assign bus.xfer_count = xferCountR;

endmodule

// File: tb/tb_pipelined_bus_mux.sv
// Scoreboard bench: dutA uses the defaults (hold on idle, fault on conflict),
// dutB uses zero-on-idle with lowest-index conflict resolution.
module tb_pipelined_bus_mux;

   typedef struct packed {
      logic [31:0] busOut;
      logic        busValid;
      logic [4:0]  selIdx;
      logic        conflict;
      logic        fault;
      logic [15:0] xferCount;
   } exp_t;

   typedef struct {
      string name;
      exp_t  v;
   } item_t;

   logic         clk = 1'b0;
   logic         clear = 1'b0;
   logic [767:0] srcData;
   logic [23:0]  srcEn = 24'd0;
   logic         errClr = 1'b0;

   int checks = 0;
   int errors = 0;
   item_t qA[$];
   item_t qB[$];

   pipelined_bus_mux_if #(.WIDTH(32), .NUM_SRC(24)) ifA ();
   pipelined_bus_mux_if #(.WIDTH(32), .NUM_SRC(24)) ifB ();

   assign ifA.src_data = srcData;
   assign ifA.src_en   = srcEn;
   assign ifA.err_clr  = errClr;
   assign ifB.src_data = srcData;
   assign ifB.src_en   = srcEn;
   assign ifB.err_clr  = errClr;

   pipelined_bus_mux #(.WIDTH(32), .NUM_SRC(24), .HOLD_ON_IDLE(1'b1), .CONFLICT_MODE(1'b1)) dutA (
      .clock (clk),
      .clear (clear),
      .bus   (ifA)
   );

   pipelined_bus_mux #(.WIDTH(32), .NUM_SRC(24), .HOLD_ON_IDLE(1'b0), .CONFLICT_MODE(1'b0)) dutB (
      .clock (clk),
      .clear (clear),
      .bus   (ifB)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [31:0] b, input logic v, input logic [4:0] s,
                               input logic c, input logic f, input logic [15:0] n);
      exp_t e;
      e.busOut = b; e.busValid = v; e.selIdx = s;
      e.conflict = c; e.fault = f; e.xferCount = n;
      return e;
   endfunction

   function automatic exp_t actA();
      return mk(ifA.bus_out, ifA.bus_valid, ifA.sel_idx, ifA.conflict, ifA.fault, ifA.xfer_count);
   endfunction

   function automatic exp_t actB();
      return mk(ifB.bus_out, ifB.bus_valid, ifB.sel_idx, ifB.conflict, ifB.fault, ifB.xfer_count);
   endfunction

   task automatic compare(input string name, input exp_t want, input exp_t got);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got bus=%h valid=%0b sel=%0d conflict=%0b fault=%0b cnt=%h, want bus=%h valid=%0b sel=%0d conflict=%0b fault=%0b cnt=%h",
                  name, got.busOut, got.busValid, got.selIdx, got.conflict, got.fault, got.xferCount,
                  want.busOut, want.busValid, want.selIdx, want.conflict, want.fault, want.xferCount);
      end
   endtask

   // Called at a falling edge: apply inputs, queue the result expected after the next rising edge.
   task automatic step(input string name, input logic [23:0] en, input logic ec,
                       input exp_t ea, input exp_t eb);
      item_t it;
      srcEn  = en;
      errClr = ec;
      it.name = {name, "/A"}; it.v = ea; qA.push_back(it);
      it.name = {name, "/B"}; it.v = eb; qB.push_back(it);
      @(negedge clk);
   endtask

   // Monitor: compares each DUT against its queue one tick after every rising edge.
   always @(posedge clk) begin
      item_t it;
      #1;
      if (qA.size() > 0) begin
         it = qA.pop_front();
         compare(it.name, it.v, actA());
      end
      if (qB.size() > 0) begin
         it = qB.pop_front();
         compare(it.name, it.v, actB());
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, got no end, want end");
      $fatal(1, "timeout");
   end

   initial begin
      exp_t z;
      exp_t e;
      z = mk(32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 16'h0);
      for (int i = 0; i < 24; i++) begin
         srcData[i*32 +: 32] = {8'hC0, 8'(i), 16'h0000};
      end
      srcData[5*32 +: 32] = 32'hDEADBEEF;
      srcData[1*32 +: 32] = 32'h12345678;

      #1 clear = 1'b1;
      #1;
      compare("reset/A", z, actA());
      compare("reset/B", z, actB());
      @(negedge clk);
      clear = 1'b0;

      step("onehot5",  24'h000020, 1'b0,
           mk(32'hDEADBEEF, 1'b1, 5'd5, 1'b0, 1'b0, 16'd1), mk(32'hDEADBEEF, 1'b1, 5'd5, 1'b0, 1'b0, 16'd1));
      step("idle1",    24'h000000, 1'b0,
           mk(32'hDEADBEEF, 1'b0, 5'd5, 1'b0, 1'b0, 16'd1), mk(32'h0, 1'b0, 5'd5, 1'b0, 1'b0, 16'd1));
      step("onehot1",  24'h000002, 1'b0,
           mk(32'h12345678, 1'b1, 5'd1, 1'b0, 1'b0, 16'd2), mk(32'h12345678, 1'b1, 5'd1, 1'b0, 1'b0, 16'd2));
      step("idle2",    24'h000000, 1'b0,
           mk(32'h12345678, 1'b0, 5'd1, 1'b0, 1'b0, 16'd2), mk(32'h0, 1'b0, 5'd1, 1'b0, 1'b0, 16'd2));
      step("multi3_9", 24'h000208, 1'b0,
           mk(32'h12345678, 1'b0, 5'd1, 1'b1, 1'b1, 16'd2), mk(32'hC0030000, 1'b1, 5'd3, 1'b1, 1'b0, 16'd3));
      step("clrmulti", 24'h000208, 1'b1,
           mk(32'h12345678, 1'b0, 5'd1, 1'b1, 1'b1, 16'd2), mk(32'hC0030000, 1'b1, 5'd3, 1'b1, 1'b0, 16'd4));
      step("faultign", 24'h000020, 1'b0,
           mk(32'h12345678, 1'b0, 5'd1, 1'b0, 1'b1, 16'd2), mk(32'hDEADBEEF, 1'b1, 5'd5, 1'b0, 1'b0, 16'd5));
      step("errclr1",  24'h000000, 1'b1,
           mk(32'h12345678, 1'b0, 5'd1, 1'b0, 1'b0, 16'd2), mk(32'h0, 1'b0, 5'd5, 1'b0, 1'b0, 16'd5));
      step("multi2_7", 24'h000084, 1'b0,
           mk(32'h12345678, 1'b0, 5'd1, 1'b1, 1'b1, 16'd2), mk(32'hC0020000, 1'b1, 5'd2, 1'b1, 1'b0, 16'd6));
      step("errclr2",  24'h000000, 1'b1,
           mk(32'h12345678, 1'b0, 5'd1, 1'b0, 1'b0, 16'd2), mk(32'h0, 1'b0, 5'd2, 1'b0, 1'b0, 16'd6));
      step("top23",    24'h800000, 1'b0,
           mk(32'hC0170000, 1'b1, 5'd23, 1'b0, 1'b0, 16'd3), mk(32'hC0170000, 1'b1, 5'd23, 1'b0, 1'b0, 16'd7));
      step("bottom0",  24'h000001, 1'b0,
           mk(32'hC0000000, 1'b1, 5'd0, 1'b0, 1'b0, 16'd4), mk(32'hC0000000, 1'b1, 5'd0, 1'b0, 1'b0, 16'd8));
      step("allhot",   24'hFFFFFF, 1'b0,
           mk(32'hC0000000, 1'b0, 5'd0, 1'b1, 1'b1, 16'd4), mk(32'hC0000000, 1'b1, 5'd0, 1'b1, 1'b0, 16'd9));
      step("fault4",   24'h000010, 1'b0,
           mk(32'hC0000000, 1'b0, 5'd0, 1'b0, 1'b1, 16'd4), mk(32'hC0040000, 1'b1, 5'd4, 1'b0, 1'b0, 16'd10));

      // Asynchronous clear while dutA sits in FAULT and dutB is mid-stream.
      clear = 1'b1;
      #1;
      compare("asyncclr/A", z, actA());
      compare("asyncclr/B", z, actB());
      @(negedge clk);
      clear  = 1'b0;
      errClr = 1'b0;

      step("postclr5", 24'h000020, 1'b0,
           mk(32'hDEADBEEF, 1'b1, 5'd5, 1'b0, 1'b0, 16'd1), mk(32'hDEADBEEF, 1'b1, 5'd5, 1'b0, 1'b0, 16'd1));

      // Stream transfers until the counter reaches FFFE, then three more must stick at FFFF.
      repeat (65533) @(negedge clk);
      e = mk(32'hDEADBEEF, 1'b1, 5'd5, 1'b0, 1'b0, 16'hFFFE);
      compare("cnt_fffe/A", e, actA());
      compare("cnt_fffe/B", e, actB());
      e = mk(32'hDEADBEEF, 1'b1, 5'd5, 1'b0, 1'b0, 16'hFFFF);
      step("sat1", 24'h000020, 1'b0, e, e);
      step("sat2", 24'h000020, 1'b0, e, e);
      step("sat3", 24'h000020, 1'b0, e, e);
      srcEn = 24'd0;

      repeat (2) @(negedge clk);
      checks++;
      if ((qA.size() != 0) || (qB.size() != 0)) begin
         errors++;
         $display("FAIL drain: got %0d/%0d pending, want 0/0", qA.size(), qB.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
